// File: rtl/ahfp_add_arb.sv
// ahfp_add_arb: round-robin arbiter plus two-stage issue/capture pipeline that
// shares one combinational ahfp_add floating-point adder between NUM_REQ
// requesters.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester handshake (at most one ready bit high)
//   req_dataa/req_datab   - per-requester operands, requester i in [32i+31:32i]
//   add_dataa/add_datab   - stage-1 operand registers, drive the shared adder
//   add_result            - combinational sum returned by the shared adder
//   rsp_valid/rsp_ready   - response handshake
//   rsp_id/rsp_result     - requester index and registered sum
module ahfp_add_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_dataa,
  input  logic [32*NUM_REQ-1:0] req_datab,
  output logic [31:0]           add_dataa,
  output logic [31:0]           add_datab,
  input  logic [31:0]           add_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result
);

  localparam int unsigned DATA_W = 32;

  // Stage 1: issue registers feeding the adder
  logic              s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]   s1_id_q,    s1_id_d;
  logic [DATA_W-1:0] s1_a_q,     s1_a_d;
  logic [DATA_W-1:0] s1_b_q,     s1_b_d;

  // Stage 2: response registers
  logic              rsp_valid_q,  rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q,     rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;

  // Round-robin pointer
  logic [ID_W-1:0]   last_grant_q, last_grant_d;

  logic              s1_en_c;
  logic              s2_en_c;
  logic              grant_found_c;
  logic [ID_W-1:0]   grant_idx_c;
  logic [ID_W-1:0]   cand_c;
  logic              take_c;

  logic [DATA_W-1:0] dataa_arr [NUM_REQ];
  logic [DATA_W-1:0] datab_arr [NUM_REQ];

  // Unpack the flat operand buses into per-requester words
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      dataa_arr[i] = req_dataa[DATA_W*i +: DATA_W];
      datab_arr[i] = req_datab[DATA_W*i +: DATA_W];
    end
  end

  // Pipeline enables: S2 drains when empty or accepted, S1 when empty or S2 moves
  always_comb begin
    s2_en_c = !rsp_valid_q || rsp_ready;
    s1_en_c = !s1_valid_q || s2_en_c;
  end

  // Rotating-priority search starting just after the last granted index;
  // the ID_W-bit add wraps naturally because NUM_REQ is a power of two.
  always_comb begin
    grant_found_c = 1'b0;
    grant_idx_c   = '0;
    cand_c        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_c = last_grant_q + ID_W'(k + 1);
      if (!grant_found_c && req_valid[cand_c]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = cand_c;
      end
    end
  end

  // Handshake qualifier; ready is suppressed while reset is asserted
  always_comb begin
    take_c    = !reset && s1_en_c && grant_found_c;
    req_ready = '0;
    if (take_c) begin
      req_ready[grant_idx_c] = 1'b1;
    end
  end

  // Next-state for both stages and the round-robin pointer
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_id_d      = s1_id_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    last_grant_d = last_grant_q;

    if (s2_en_c) begin
      rsp_valid_d  = s1_valid_q;
      rsp_id_d     = s1_id_q;
      rsp_result_d = add_result;
    end

    // Operands only move on a handshake; an empty slot just clears valid
    if (s1_en_c) begin
      s1_valid_d = take_c;
      if (take_c) begin
        s1_id_d = grant_idx_c;
        s1_a_d  = dataa_arr[grant_idx_c];
        s1_b_d  = datab_arr[grant_idx_c];
      end
    end

    if (take_c) begin
      last_grant_d = grant_idx_c;
    end
  end

  // State registers; last_grant resets to the top index so requester 0 wins first
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign add_dataa  = s1_a_q;
  assign add_datab  = s1_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: doc/ahfp_add_arb.md
# ahfp_add_arb

Round-robin arbiter and two-stage issue/capture pipeline that shares one combinational `ahfp_add` floating-point adder between `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block registers the winning operands, drives them into the external `ahfp_add`, and returns the registered sum tagged with the requester's ID over a valid/ready response channel. It sits between the custom-instruction front ends and the single shared adder instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; must be a power of two, 2..8.
- `ID_W`, default 2: width of the requester ID; equals log2(`NUM_REQ`).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req_valid`, input, `NUM_REQ`: bit i = requester i has an operand pair pending.
- `req_ready`, output, `NUM_REQ`: bit i = requester i is accepted this cycle; at most one bit high.
- `req_dataa`, input, 32*`NUM_REQ`: requester i operand A in bits [32i+31:32i].
- `req_datab`, input, 32*`NUM_REQ`: requester i operand B, same packing.
- `add_dataa`, output, 32: to the `ahfp_add` `dataa` input; the stage-1 operand A register.
- `add_datab`, output, 32: to the `ahfp_add` `datab` input; the stage-1 operand B register.
- `add_result`, input, 32: from the `ahfp_add` `result` output; combinational in `add_dataa`/`add_datab`.
- `rsp_valid`, output, 1: response registers hold a result.
- `rsp_ready`, input, 1: consumer accepts the response.
- `rsp_id`, output, `ID_W`: index of the requester that issued the result.
- `rsp_result`, output, 32: registered sum.

## Operation
- Stage 1 (S1) holds: `s1_valid`, `s1_id`, operand A, operand B. Operands A/B drive `add_dataa`/`add_datab` directly.
- Stage 2 (S2) holds: `rsp_valid`, `rsp_id`, `rsp_result`.
- S2 load enable is `s2_en = !rsp_valid || rsp_ready`.
  - When `s2_en` is high, S2 loads `rsp_valid <= s1_valid`, `rsp_id <= s1_id`, `rsp_result <= add_result`.
  - When `s2_en` is low, S2 holds.
- S1 load enable is `s1_en = !s1_valid || s2_en`.
  - When `s1_en` is high, S1 loads the granted request, or clears `s1_valid` if there is no grant.
  - When `s1_en` is low, S1 holds its operands and ID.
- Arbitration, computed combinationally each cycle:
  - Search `req_valid` starting at index `(last_grant + 1) mod NUM_REQ` and ascending with wrap. The first set bit wins.
  - `req_ready[w] = s1_en && req_valid[w]`. All other `req_ready` bits are 0.
  - `last_grant` updates to w only on a completed handshake (`req_valid[w] && req_ready[w]`).
- `req_ready` depends combinationally on `req_valid`. Requesters must not derive `req_valid` from `req_ready`.
- A requester holding `req_valid` high while not granted must keep its data stable. The block samples data only on handshake.
- No reordering: responses leave in grant order. There is no internal buffering beyond S1/S2, so at most 2 operations are in flight.
- Arithmetic is entirely inside `ahfp_add`. The block passes `add_result` through unmodified: no rounding, sign or exception handling.

## Timing
- Reset values (synchronous; applied at the first rising edge with `reset` high):
  - `s1_valid` = 0; `rsp_valid` = 0.
  - `rsp_id` = 0; `rsp_result` = 32'h0.
  - `add_dataa` = `add_datab` = 32'h0.
  - `last_grant` = `NUM_REQ`-1, so requester 0 has first priority.
- `req_ready` is all-zero while `reset` is high.
- Latency: handshake in cycle n gives `rsp_valid` high in cycle n+2, with no backpressure.
- Throughput: one accepted request per cycle while `rsp_ready` stays high.
- Backpressure: `rsp_ready` low with S2 full freezes S2.
  - S1 still accepts one request if it is empty.
  - Once S1 is full, all `req_ready` are 0.
  - In the cycle `rsp_ready` returns high, both stages advance and a new grant is issued in that same cycle.
- Simultaneous events:
  - Response accept and new grant in the same cycle is legal and loses nothing.
  - A single requester that is continuously valid is granted every cycle, since the round-robin pointer wraps back to it.
- Reset mid-operation discards both in-flight operations; no response is produced for them.
- `rsp_valid`, `rsp_id` and `rsp_result` stay stable while `rsp_valid && !rsp_ready`.

## Test plan
- Bench instantiates `ahfp_add` between `add_*` ports; `NUM_REQ`=4.
- Single request: requester 2 presents A=32'h3F800000, B=32'h3F800000 at cycle 5, `rsp_ready`=1 → `req_ready`=4'b0100 in cycle 5; `rsp_valid`=1, `rsp_id`=2, `rsp_result`=32'h40000000 in cycle 7 only.
- Fairness: all four `req_valid` high from reset release and held → grants in order 0,1,2,3,0,1 on consecutive cycles. Then only requesters 0 and 3 stay valid after a grant to 3 → next grant is 0, then 3.
- Backpressure: requester 1 streams 6 distinct operand pairs, and `rsp_ready` is low for cycles 3-5 → `req_ready` drops once S1 and S2 are both full. All 6 responses arrive in order with correct sums and none are lost or duplicated. Outputs are held stable while stalled.
- Back-to-back throughput: requester 3 continuously valid for 10 cycles with `rsp_ready`=1 → 10 handshakes in 10 cycles, and `rsp_valid` is high for 10 consecutive cycles.
- Reset mid-operation: assert `reset` for one cycle while both stages are full → next cycle `rsp_valid`=0, `add_dataa`=0, and no stale response appears. A subsequent simultaneous request from 0 and 1 is granted to 0 first.
